// File: rtl/yubex_tla_pkg.sv
// Shared definitions for the tiny pattern generator / logic analyzer pair.
// Holds the waveform mode encodings, the generator FSM states, the LFSR
// constants and the 7-segment digit patterns. Segment a is bit 0, and the
// segment outputs are active-high.
package yubex_tla_pkg;

   typedef enum logic [2:0] {
      MODE_LOW    = 3'd0,
      MODE_HIGH   = 3'd1,
      MODE_SQUARE = 3'd2,
      MODE_RISE   = 3'd3,
      MODE_FALL   = 3'd4,
      MODE_PULSE  = 3'd5,
      MODE_PRBS   = 3'd6,
      MODE_BURST  = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ONESHOT = 2'd1,
      CONT    = 2'd2
   } state_e;

   localparam logic [7:0] LFSR_SEED  = 8'h01;
   // x^8+x^6+x^5+x^4+1 as a Fibonacci register: feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;
   // Burst = 4 pulses of 1 tick high / 1 tick low; the last tick index is 7
   localparam logic [7:0] BURST_LAST = 8'd7;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;

   function automatic logic [6:0] seg_digit(input logic [2:0] d);
      logic [6:0] s;
      case (d)
         3'd0:    s = SEG_0;
         3'd1:    s = SEG_1;
         3'd2:    s = SEG_2;
         3'd3:    s = SEG_3;
         3'd4:    s = SEG_4;
         3'd5:    s = SEG_5;
         3'd6:    s = SEG_6;
         default: s = SEG_7;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], ^(l & LFSR_TAPS)};
   endfunction

   // Output level driven in the cycle a mode is started
   function automatic logic mode_init(input mode_e m);
      return !(m == MODE_LOW || m == MODE_RISE);
   endfunction

   // Modes that finish on their own and fall back to IDLE
   function automatic logic mode_oneshot(input mode_e m);
      return (m == MODE_RISE) || (m == MODE_FALL) ||
             (m == MODE_PULSE) || (m == MODE_BURST);
   endfunction

endpackage

// File: rtl/yubex_tick_prescaler.sv
// Bit-period prescaler. Counts 0..DIV-1 and flags tick while the count sits
// at DIV-1, then wraps. clr restarts the period so a new waveform gets a full
// first bit.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   clr  in  synchronous restart of the count
//   tick out one-cycle strobe every DIV clocks
module yubex_tick_prescaler #(
   parameter logic [13:0] DIV = 14'd1250
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   logic [13:0] r_cnt;

   assign tick = (r_cnt == DIV - 14'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              r_cnt <= '0;
      else if (clr || tick) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 14'd1;
   end

endmodule

// File: rtl/yubex_tiny_pattern_generator.sv
// Programmable single-pin stimulus source. A rising edge on start (asynchronous,
// synchronized here) latches mode and launches a static level, single edge,
// pulse, square wave, pulse burst or PRBS on pattern_out. The latched mode is
// shown on a 7-segment digit.
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   mode[2:0]   in  waveform select, sampled only on an accepted start
//   start       in  asynchronous start request, rising edge accepted
//   pattern_out out registered waveform
//   busy        out high while a waveform is running
//   seg[6:0]    out 7-segment digit of the latched mode (a = bit 0)
module yubex_tiny_pattern_generator
   import yubex_tla_pkg::*;
#(
   parameter logic [13:0] DIV         = 14'd1250,
   parameter logic [7:0]  PULSE_TICKS = 8'd4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mode,
   input  logic       start,
   output logic       pattern_out,
   output logic       busy,
   output logic [6:0] seg
);

   logic       r_s0, r_s1, r_s2;
   state_e     r_state, w_state_nxt;
   mode_e      r_mode_q, w_mode_nxt;
   logic [7:0] r_lfsr, w_lfsr_nxt;
   logic [7:0] r_tcnt, w_tcnt_nxt;
   logic       r_pattern, w_pat_nxt;
   logic       w_start_pulse;
   logic       w_tick;

   // s0/s1 resolve metastability, s2 gives the edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0 <= 1'b0;
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s0 <= start;
         r_s1 <= r_s0;
         r_s2 <= r_s1;
      end
   end

   assign w_start_pulse = r_s1 & ~r_s2;

   yubex_tick_prescaler #(.DIV(DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_start_pulse),
      .tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mode_q  <= MODE_LOW;
         r_lfsr    <= LFSR_SEED;
         r_tcnt    <= '0;
         r_pattern <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode_q  <= w_mode_nxt;
         r_lfsr    <= w_lfsr_nxt;
         r_tcnt    <= w_tcnt_nxt;
         r_pattern <= w_pat_nxt;
      end
   end

   // A start always wins over a coincident tick, so a restart begins with a
   // full first bit period.
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode_q;
      w_lfsr_nxt  = r_lfsr;
      w_tcnt_nxt  = r_tcnt;
      w_pat_nxt   = r_pattern;
      if (w_start_pulse) begin
         w_mode_nxt  = mode_e'(mode);
         w_lfsr_nxt  = LFSR_SEED;
         w_tcnt_nxt  = '0;
         w_pat_nxt   = mode_init(mode_e'(mode));
         w_state_nxt = mode_oneshot(mode_e'(mode)) ? ONESHOT : CONT;
      end else if (w_tick) begin
         case (r_state)
            CONT: begin
               case (r_mode_q)
                  MODE_SQUARE: w_pat_nxt = ~r_pattern;
                  MODE_PRBS: begin
                     w_lfsr_nxt = lfsr_next(r_lfsr);
                     w_pat_nxt  = w_lfsr_nxt[0];
                  end
                  default: ;
               endcase
            end
            ONESHOT: begin
               case (r_mode_q)
                  MODE_RISE: begin
                     w_pat_nxt   = 1'b1;
                     w_state_nxt = IDLE;
                  end
                  MODE_PULSE: begin
                     if (r_tcnt == PULSE_TICKS - 8'd1) begin
                        w_pat_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                     end else begin
                        w_tcnt_nxt = r_tcnt + 8'd1;
                     end
                  end
                  MODE_BURST: begin
                     // ticks 1..7 toggle; the 8th ends low
                     if (r_tcnt == BURST_LAST) begin
                        w_pat_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                     end else begin
                        w_pat_nxt  = ~r_pattern;
                        w_tcnt_nxt = r_tcnt + 8'd1;
                     end
                  end
                  default: begin
                     // MODE_FALL: single falling edge
                     w_pat_nxt   = 1'b0;
                     w_state_nxt = IDLE;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   assign pattern_out = r_pattern;
   assign busy        = (r_state != IDLE);
   assign seg         = seg_digit(r_mode_q);

endmodule

// File: tb/tb_yubex_tiny_pattern_generator.sv
// Bench for yubex_tiny_pattern_generator: three instances with different
// DIV/PULSE_TICKS share stimulus. A reference model pushes the expected
// outputs every clock; a monitor pops and compares on the falling edge.
module tb_yubex_tiny_pattern_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [2:0] pat;
   logic [2:0] bsy;
   logic [6:0] sg0, sg1, sg2;

   int n_cmp = 0;
   int n_bad = 0;

   yubex_tiny_pattern_generator #(.DIV(14'd4), .PULSE_TICKS(8'd4)) u_a (
      .clk(clk), .rst(rst), .mode(mode), .start(start),
      .pattern_out(pat[0]), .busy(bsy[0]), .seg(sg0));
   yubex_tiny_pattern_generator #(.DIV(14'd2), .PULSE_TICKS(8'd3)) u_b (
      .clk(clk), .rst(rst), .mode(mode), .start(start),
      .pattern_out(pat[1]), .busy(bsy[1]), .seg(sg1));
   yubex_tiny_pattern_generator #(.DIV(14'd1), .PULSE_TICKS(8'd4)) u_c (
      .clk(clk), .rst(rst), .mode(mode), .start(start),
      .pattern_out(pat[2]), .busy(bsy[2]), .seg(sg2));

   always #5 clk = ~clk;

   function automatic int div_of(int i);
      return (i == 0) ? 4 : (i == 1) ? 2 : 1;
   endfunction
   function automatic int pt_of(int i);
      return (i == 1) ? 3 : 4;
   endfunction

   logic [6:0] seg_tab [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};
   bit prbs [255];

   // Expected {busy, pattern} k clocks after the start action
   function automatic logic [1:0] expect_pb(int m, int k, int div, int pt);
      int t;
      t = k / div;
      case (m)
         0: return 2'b10;
         1: return 2'b11;
         2: return {1'b1, (t % 2) == 0};
         3: return (t == 0) ? 2'b10 : 2'b01;
         4: return (t == 0) ? 2'b11 : 2'b00;
         5: return (t < pt) ? 2'b11 : 2'b00;
         6: return {1'b1, prbs[t % 255]};
         default: return (t < 8) ? {1'b1, (t % 2) == 0} : 2'b00;
      endcase
   endfunction

   typedef struct {
      logic [2:0] pat;
      logic [2:0] bsy;
      logic [6:0] seg;
   } exp_t;
   exp_t sb[$];

   // Reference model: start seen high at edge n-2 and low at n-3 acts at n
   initial begin
      int       m_mode;
      int       m_k;
      bit       m_active;
      bit [2:0] h;
      exp_t     e;
      logic [7:0] l;
      logic [1:0] pb;
      l = 8'h01;
      for (int t = 0; t < 255; t++) begin
         prbs[t] = l[0];
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      m_mode = 0; m_k = 0; m_active = 0; h = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_active = 0; m_mode = 0; h = '0;
         end else begin
            if (h[1] && !h[2]) begin
               m_active = 1; m_mode = int'(mode); m_k = 0;
            end else begin
               m_k++;
            end
            h = {h[1:0], start};
         end
         for (int i = 0; i < 3; i++) begin
            pb = m_active ? expect_pb(m_mode, m_k, div_of(i), pt_of(i)) : 2'b00;
            e.bsy[i] = pb[1];
            e.pat[i] = pb[0];
         end
         e.seg = seg_tab[m_mode];
         sb.push_back(e);
      end
   end

   // Monitor
   initial begin
      exp_t e;
      logic [6:0] sa [3];
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            sa[0] = sg0; sa[1] = sg1; sa[2] = sg2;
            for (int i = 0; i < 3; i++) begin
               n_cmp += 3;
               if (pat[i] !== e.pat[i]) begin
                  n_bad++;
                  $display("FAIL pattern_out[%0d] t=%0t got %b want %b", i, $time, pat[i], e.pat[i]);
               end
               if (bsy[i] !== e.bsy[i]) begin
                  n_bad++;
                  $display("FAIL busy[%0d] t=%0t got %b want %b", i, $time, bsy[i], e.bsy[i]);
               end
               if (sa[i] !== e.seg) begin
                  n_bad++;
                  $display("FAIL seg[%0d] t=%0t got %h want %h", i, $time, sa[i], e.seg);
               end
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(int m, int hold);
      mode  = 3'(m);
      start = 1'b1;
      cyc(hold);
      start = 1'b0;
   endtask

   initial begin
      logic [8:0] lfsr_exp;
      lfsr_exp = 9'b100011100;  // first value in the MSB
      // reset, then idle with no start
      cyc(3);
      rst = 1'b0;
      cyc(100);

      // square wave, then a mode change without a start
      pulse_start(2, 3);
      cyc(40);
      mode = 3'd5;
      cyc(20);

      // single pulse
      pulse_start(5, 2);
      cyc(40);

      // PRBS with start held high: one action only
      mode  = 3'd6;
      start = 1'b1;
      cyc(3);                        // now just after E2
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (pat[2] !== lfsr_exp[8-i]) begin
            n_bad++;
            $display("FAIL prbs_seq[%0d] got %b want %b", i, pat[2], lfsr_exp[8-i]);
         end
         cyc(1);
      end
      cyc(20);
      start = 1'b0;
      cyc(280);

      // burst aborted by a restart in single-rise mode
      pulse_start(7, 3);
      cyc(5);
      pulse_start(3, 3);
      cyc(40);

      // async reset mid-burst
      pulse_start(7, 3);
      cyc(9);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp += 2;
         if (pat[i] !== 1'b0 || bsy[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst[%0d] got pat=%b busy=%b want 0 0", i, pat[i], bsy[i]);
         end
      end
      cyc(3);
      rst = 1'b0;
      cyc(30);

      // randomized starts and idle mode changes
      for (int r = 0; r < 60; r++) begin
         pulse_start(int'($urandom_range(0, 7)), int'($urandom_range(1, 5)));
         cyc(int'($urandom_range(2, 30)));
         if ($urandom_range(0, 1) == 1) mode = 3'($urandom_range(0, 7));
         cyc(int'($urandom_range(2, 40)));
      end

      cyc(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/yubex_tiny_pattern_generator.md
# yubex_tiny_pattern_generator

Programmable digital stimulus source: on a start request it drives a selected test waveform (static level, single edge, pulse, square wave, pulse burst or pseudo-random bit stream) on one output pin. The selected mode is shown on a 7-segment display. The block is the transmit-side companion to the tiny logic analyzer. Wiring `pattern_out` to the analyzer's `data_in` makes a self-contained loopback demo on the same tile.

## Interface
- `DIV`, default 14'd1250: bit period in clk cycles (tick every `DIV` clocks). Legal range 1..16383.
- `PULSE_TICKS`, default 8'd4: high length of mode-5 pulse, in ticks. Legal range 1..255.
- `clk`  in  1  system clock (12.5 kHz nominal)
- `rst`  in  1  reset; asynchronous, active-high
- `mode`  in  3  waveform select; sampled only on an accepted start
- `start`  in  1  asynchronous start request; rising edge accepted
- `pattern_out`  out  1  generated waveform, registered
- `busy`  out  1  high while a waveform is running
- `seg`  out  7  7-segment digit of the latched mode; segment a = bit 0, active-high

## Operation
- Start conditioning:
  - `start` passes through a 2-FF synchronizer (`s0`, `s1`) plus a delay FF `s2`.
  - `start_pulse = s1 & ~s2`.
- Action on `start_pulse` (any state; a start always restarts):
  - latch `mode` into `mode_q`;
  - clear the prescaler and the tick counter;
  - load the LFSR with 8'h01;
  - set `pattern_out` to the mode's initial value;
  - enter the mode's state.
- Prescaler: count 0..DIV-1; `tick` is asserted in the cycle where count == DIV-1; the count then wraps to 0.
- FSM states: `IDLE`, `ONESHOT`, `CONT`.
- Behaviour per mode (initial value -> behaviour):
  - 0: 0 -> `CONT`, static low.
  - 1: 1 -> `CONT`, static high.
  - 2: 1 -> `CONT`, toggle on every tick (period 2*DIV).
  - 3: 0 -> `ONESHOT`; first tick sets 1 and goes to `IDLE`.
  - 4: 1 -> `ONESHOT`; first tick sets 0 and goes to `IDLE`.
  - 5: 1 -> `ONESHOT`; after `PULSE_TICKS` ticks sets 0 and goes to `IDLE`.
  - 6: 1 -> `CONT`, LFSR stream.
  - 7: 1 -> `ONESHOT`, burst of 4 pulses: 1 tick high, 1 tick low. After the 8th tick, output 0 and go to `IDLE`.
- LFSR (mode 6):
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - `fb = l[7]^l[5]^l[4]^l[3]`.
  - Each tick: `l <= {l[6:0], fb}`.
  - `pattern_out = l[0]` after each tick; period 255 ticks.
- `IDLE` holds the last `pattern_out`. The prescaler keeps free-running in `IDLE` but has no effect.
- `busy` = (state != `IDLE`). `CONT` is exited only by `rst`. A new start during `CONT` restarts in the new mode.
- A change on `mode` without a start has no effect.
- `seg` decodes `mode_q`: 0..7 use the standard digit patterns.

## Timing
- Reset values:
  - `pattern_out` = 0, `busy` = 0, state `IDLE`, `mode_q` = 0 (`seg` shows "0");
  - LFSR 8'h01; prescaler 0; synchronizer 0.
- Start latency: `start` rises before edge E0. The start action is registered at edge E2, and `pattern_out`/`busy` change after E2.
- First tick occurs DIV cycles after E2, so the first post-start transition is registered at edge E2+DIV.
- With `DIV` = 1 a tick occurs every cycle, and a one-tick pulse lasts 1 clk.
- `start` held high produces only one start action. A second action needs a low level for at least 2 clk.
- Reset mid-operation: outputs return to reset values immediately (asynchronous) and no residual tick is produced.

## Structure
- Shared package `yubex_tla_pkg`:
  - mode encodings `MODE_LOW`..`MODE_BURST` (3'd0..3'd7);
  - FSM state encoding;
  - LFSR seed 8'h01 and tap mask;
  - 7-segment digit constants. The display encoding is shared with the analyzer.
- One sub-module: `yubex_tick_prescaler`. Parameter `DIV`; inputs clk, rst, clr; output `tick`.
- The FSM, LFSR and segment decode stay in the top.

## Test plan
- Reset release with no start -> `pattern_out` = 0, `busy` = 0, `seg` = 7'h3F ("0") for 100 cycles.
- DIV=4, mode 2, start -> `pattern_out` = 1 after E2, toggles every 4 clk (period 8), `busy` stays 1, `seg` = 7'h5B ("2").
- DIV=2, PULSE_TICKS=3, mode 5 -> high exactly 6 clk starting at E2, then 0, `busy` falls on the same edge.
- DIV=1, mode 6 -> `pattern_out` sequence 1,0,0,0,1,1,1,0,0 on consecutive cycles from E2; repeats after 255 ticks.
- DIV=2, mode 7, restart with mode 3 after the 2nd pulse -> burst aborts, `pattern_out` = 0 after the new E2, 1 two cycles later, then `IDLE`.
- Mode change without start during mode 2, and `rst` asserted mid-burst -> mode change has no effect; `rst` forces `pattern_out` = 0 and `busy` = 0 asynchronously, with no further edges.
